// File: rtl/core_pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and its sequencing controller (slave).
interface core_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_memread;
  logic [4:0]       ex_reg_rt;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ll;
  logic             mem_sc;
  logic             mem_ack;
  logic             inv_hit;

  logic             mem_start;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             id_ex_hold;
  logic             ex_mem_hold;
  logic             mem_wb_bubble;
  logic             llbit;
  logic             sc_fail;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_memread, ex_reg_rt, ex_branch_taken,
           mem_req, mem_ll, mem_sc, mem_ack, inv_hit,
    input  mem_start, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold,
           ex_mem_hold, mem_wb_bubble, llbit, sc_fail, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_memread, ex_reg_rt, ex_branch_taken,
           mem_req, mem_ll, mem_sc, mem_ack, inv_hit,
    output mem_start, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold,
           ex_mem_hold, mem_wb_bubble, llbit, sc_fail, stall_cnt
  );
endinterface

// File: rtl/core_pipe_ctrl.sv
// Five-stage pipeline sequencing: load-use bubbles, branch flushes, multi-cycle MEM holds,
// LL/SC link tracking and a saturating stall-cycle counter.
module core_pipe_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  core_pipe_ctrl_if.slave   bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             llbit_q, llbit_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic sc_fail;
  logic mem_busy;
  logic branch_flush;
  logic load_use;
  logic stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      llbit_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      llbit_q     <= llbit_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    sc_fail      = bus.mem_sc & ~llbit_q;
    mem_busy     = bus.mem_req & ~bus.mem_ack & ~sc_fail;
    branch_flush = bus.ex_branch_taken & ~mem_busy;
    // rt compare only counts when the ID instruction actually reads rt; r0 never hazards.
    load_use     = bus.ex_mem_memread & (bus.ex_reg_rt != 5'd0)
                 & ((bus.ex_reg_rt == bus.id_rs)
                    | (bus.id_uses_rt & (bus.ex_reg_rt == bus.id_rt)))
                 & ~mem_busy & ~bus.ex_branch_taken;
    stall        = mem_busy | load_use;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_busy)    state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack) state_d = RUN;
      default:                   state_d = RUN;
    endcase
  end

  // Clear has priority so an invalidate racing an LL completion leaves the link broken.
  always_comb begin
    llbit_d = llbit_q;
    if (bus.inv_hit | (bus.mem_sc & bus.mem_ack)) begin
      llbit_d = 1'b0;
    end else if (bus.mem_ll & bus.mem_ack) begin
      llbit_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.mem_start     = (state_q == RUN) & bus.mem_req & ~sc_fail;
    bus.pc_stall      = stall;
    bus.if_id_stall   = stall;
    bus.if_id_flush   = branch_flush;
    bus.id_ex_bubble  = branch_flush | load_use;
    bus.id_ex_hold    = mem_busy;
    bus.ex_mem_hold   = mem_busy;
    bus.mem_wb_bubble = mem_busy;
    bus.llbit         = llbit_q;
    bus.sc_fail       = sc_fail;
    bus.stall_cnt     = stall_cnt_q;
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Randomized and directed checks of core_pipe_ctrl against a cycle-level reference model.
module tb_core_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_pipe_ctrl_if #(.CNT_W(16)) bus ();
  core_pipe_ctrl_if #(.CNT_W(4))  sbus ();

  core_pipe_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  core_pipe_ctrl #(.CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(sbus));

  assign sbus.id_rs           = bus.id_rs;
  assign sbus.id_rt           = bus.id_rt;
  assign sbus.id_uses_rt      = bus.id_uses_rt;
  assign sbus.ex_mem_memread  = bus.ex_mem_memread;
  assign sbus.ex_reg_rt       = bus.ex_reg_rt;
  assign sbus.ex_branch_taken = bus.ex_branch_taken;
  assign sbus.mem_req         = bus.mem_req;
  assign sbus.mem_ll          = bus.mem_ll;
  assign sbus.mem_sc          = bus.mem_sc;
  assign sbus.mem_ack         = bus.mem_ack;
  assign sbus.inv_hit         = bus.inv_hit;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: outstanding-access flag, link bit, unbounded stall count.
  bit m_wait = 0;
  bit m_link = 0;
  int m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.ex_mem_memread = 1'b0; bus.ex_reg_rt = 5'd0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ll = 1'b0; bus.mem_sc = 1'b0;
    bus.mem_ack = 1'b0; bus.inv_hit = 1'b0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_link = 0; m_cnt = 0;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    bit sf, busy, start, flush, lu, stl, hz;
    int exp16, exp4;
    sf    = bus.mem_sc && !m_link;
    busy  = bus.mem_req && !bus.mem_ack && !sf;
    start = !m_wait && bus.mem_req && !sf;
    flush = bus.ex_branch_taken && !busy;
    hz    = (bus.ex_reg_rt == bus.id_rs) || (bus.id_uses_rt && bus.ex_reg_rt == bus.id_rt);
    lu    = bus.ex_mem_memread && bus.ex_reg_rt != 0 && hz && !busy && !bus.ex_branch_taken;
    stl   = busy || lu;
    exp16 = (m_cnt > 65535) ? 65535 : m_cnt;
    exp4  = (m_cnt > 15) ? 15 : m_cnt;
    @(negedge clk);
    check("mem_start",     {31'd0, bus.mem_start},     {31'd0, start});
    check("pc_stall",      {31'd0, bus.pc_stall},      {31'd0, stl});
    check("if_id_stall",   {31'd0, bus.if_id_stall},   {31'd0, stl});
    check("if_id_flush",   {31'd0, bus.if_id_flush},   {31'd0, flush});
    check("id_ex_bubble",  {31'd0, bus.id_ex_bubble},  {31'd0, flush || lu});
    check("id_ex_hold",    {31'd0, bus.id_ex_hold},    {31'd0, busy});
    check("ex_mem_hold",   {31'd0, bus.ex_mem_hold},   {31'd0, busy});
    check("mem_wb_bubble", {31'd0, bus.mem_wb_bubble}, {31'd0, busy});
    check("llbit",         {31'd0, bus.llbit},         {31'd0, m_link});
    check("sc_fail",       {31'd0, bus.sc_fail},       {31'd0, sf});
    check("stall_cnt",     {16'd0, bus.stall_cnt},     exp16);
    check("stall_cnt4",    {28'd0, sbus.stall_cnt},    exp4);
    @(posedge clk);
    m_wait = m_wait ? !bus.mem_ack : busy;
    if (bus.inv_hit || (bus.mem_sc && bus.mem_ack)) m_link = 0;
    else if (bus.mem_ll && bus.mem_ack)             m_link = 1;
    if (stl) m_cnt++;
    #1;
  endtask

  task automatic sync_reset_pulse();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    check("rst_llbit",     {31'd0, bus.llbit},     32'd0);
    check("rst_pc_stall",  {31'd0, bus.pc_stall},  32'd0);
    rst = 1'b1;

    // Load-use on rs, then the load advances and the hazard is gone.
    bus.ex_mem_memread = 1'b1; bus.ex_reg_rt = 5'd5; bus.id_rs = 5'd5;
    cycle();
    idle_inputs();
    cycle();
    check("lu_cnt", {16'd0, bus.stall_cnt}, 32'd1);
    // r0 destination never hazards.
    bus.ex_mem_memread = 1'b1; bus.ex_reg_rt = 5'd0; bus.id_rs = 5'd0;
    cycle();
    check("lu_r0_cnt", {16'd0, bus.stall_cnt}, 32'd1);
    idle_inputs();

    // Miss acked in the fourth cycle.
    bus.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    bus.mem_ack = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check("miss_cnt", {16'd0, bus.stall_cnt}, 32'd4);

    // Miss + branch + load-use together, then ack with branch still taken.
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    bus.ex_mem_memread = 1'b1; bus.ex_reg_rt = 5'd7; bus.id_rs = 5'd7;
    cycle();
    bus.mem_ack = 1'b1;
    cycle();
    idle_inputs();
    check("simul_cnt", {16'd0, bus.stall_cnt}, 32'd5);

    // LL then SC, both single-cycle hits.
    bus.mem_req = 1'b1; bus.mem_ll = 1'b1; bus.mem_ack = 1'b1;
    cycle();
    check("ll_set", {31'd0, bus.llbit}, 32'd1);
    bus.mem_ll = 1'b0; bus.mem_sc = 1'b1;
    cycle();
    check("sc_clr", {31'd0, bus.llbit}, 32'd0);
    idle_inputs();

    // LL, invalidate, then SC fails without access or stall.
    bus.mem_req = 1'b1; bus.mem_ll = 1'b1; bus.mem_ack = 1'b1;
    cycle();
    idle_inputs();
    bus.inv_hit = 1'b1;
    cycle();
    idle_inputs();
    bus.mem_req = 1'b1; bus.mem_sc = 1'b1;
    cycle();
    idle_inputs();

    // Reach stall_cnt=7 inside MEM_WAIT with the link set, then reset asynchronously.
    bus.mem_req = 1'b1; bus.mem_ll = 1'b1; bus.mem_ack = 1'b1;
    cycle();
    bus.mem_ack = 1'b0; bus.mem_ll = 1'b0;
    cycle();
    cycle();
    check("pre_rst_cnt", {16'd0, bus.stall_cnt}, 32'd7);
    #3;
    rst = 1'b0;
    #1;
    check("arst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
    check("arst_llbit", {31'd0, bus.llbit},     32'd0);
    check("arst_run",   {31'd0, bus.mem_start}, 32'd1);
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    // A late ack with no request must be ignored.
    bus.mem_ack = 1'b1;
    cycle();
    idle_inputs();
    bus.mem_req = 1'b1;
    cycle();
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (!m_wait) begin
        bus.mem_req = ($urandom_range(0, 9) < 3);
        bus.mem_ll  = 1'b0;
        bus.mem_sc  = 1'b0;
        if (bus.mem_req) begin
          case ($urandom_range(0, 3))
            0: bus.mem_ll = 1'b1;
            1: bus.mem_sc = 1'b1;
            default: ;
          endcase
        end
      end
      bus.mem_ack         = ($urandom_range(0, 9) < 4);
      bus.ex_branch_taken = ($urandom_range(0, 9) < 2);
      bus.ex_mem_memread  = ($urandom_range(0, 9) < 4);
      bus.ex_reg_rt       = 5'($urandom_range(0, 3));
      bus.id_rs           = 5'($urandom_range(0, 3));
      bus.id_rt           = 5'($urandom_range(0, 3));
      bus.id_uses_rt      = 1'($urandom_range(0, 1));
      bus.inv_hit         = ($urandom_range(0, 9) < 1);
      cycle();
    end
    idle_inputs();

    // Saturation: 20 stalled cycles against the 4-bit counter.
    sync_reset_pulse();
    bus.ex_mem_memread = 1'b1; bus.ex_reg_rt = 5'd5; bus.id_rs = 5'd5;
    for (int i = 0; i < 20; i++) cycle();
    idle_inputs();
    check("sat_cnt4",  {28'd0, sbus.stall_cnt}, 32'd15);
    check("sat_cnt16", {16'd0, bus.stall_cnt},  32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
